// File: rtl/ssd_display_arbiter_pkg.sv
// Shared definitions for the seven-segment display arbiter.
//   N_REQ      : number of requesters competing for the display
//   DIGITS     : digits per scanned frame
//   BLANK_ALL  : blank mask with every digit dark
//   arb_state_e: arbiter FSM encoding (2-bit)
//   rr_pick    : round-robin selection starting after the last owner
package ssd_display_arbiter_pkg;

  localparam int         N_REQ     = 3;
  localparam int         DIGITS    = 8;
  localparam logic [7:0] BLANK_ALL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_SWITCH = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Scan the requesters beginning at (last + 1) mod N_REQ and return the
  // first one that is valid. The last owner is visited last, so it is only
  // re-chosen when nobody else is asking.
  function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] valid,
                                       input logic [1:0]       last);
    rr_pick_t   r;
    logic [1:0] cand;
    r    = '0;
    cand = last;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == 2'(N_REQ - 1)) ? 2'd0 : cand + 2'd1;
      if (!r.found && valid[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ssd_display_arbiter_if.sv
// Bundle of the request side and display side of the arbiter.
//   master : requester/driver view (drives requests, observes grant/display)
//   slave  : arbiter view (consumes requests, drives grant/display)
// Handshake: req_valid[k] is a level request with no ready; requester k owns
// the display while grant[k] is high. A requester drops the grant by lowering
// req_valid[k]; the arbiter only acts on that at the next frame boundary.
interface ssd_display_arbiter_if;
  import ssd_display_arbiter_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [32*N_REQ-1:0]     req_data;
  logic [DIGITS*N_REQ-1:0] req_blank;
  logic [N_REQ-1:0]        grant;
  logic [31:0]             disp_data;
  logic [DIGITS-1:0]       disp_blank;
  logic                    digit_tick;
  logic [2:0]              digit_idx;
  logic                    frame_done;
  arb_state_e              dbg_state;

  modport master (
    output req_valid, req_data, req_blank,
    input  grant, disp_data, disp_blank, digit_tick, digit_idx, frame_done,
           dbg_state
  );

  modport slave (
    input  req_valid, req_data, req_blank,
    output grant, disp_data, disp_blank, digit_tick, digit_idx, frame_done,
           dbg_state
  );
endinterface

// File: rtl/ssd_display_arbiter_scan.sv
// Free-running scan timer: prescaler plus digit counter.
//   ssd_clk, ssd_rst_n : clock, async active-low reset
//   o_digit_tick       : one-cycle pulse per digit slot
//   o_digit_idx        : digit currently scanned, 0..7
//   o_frame_done       : pulse with the tick that wraps digit 7 -> 0
module ssd_scan_timer
  import ssd_display_arbiter_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       ssd_clk,
  input  logic       ssd_rst_n,
  output logic       o_digit_tick,
  output logic [2:0] o_digit_idx,
  output logic       o_frame_done
);

  localparam int                   PRESC_W    = $clog2(REFRESH_DIV);
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

  logic [PRESC_W-1:0] r_presc;
  logic [2:0]         r_digit_idx;
  logic               w_tick;

  // Tick is decoded from the count, so it is low while reset holds r_presc at 0.
  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge ssd_clk or negedge ssd_rst_n) begin
    if (!ssd_rst_n) begin
      r_presc     <= '0;
      r_digit_idx <= '0;
    end else begin
      if (w_tick) begin
        r_presc     <= '0;
        r_digit_idx <= r_digit_idx + 3'd1;
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end
    end
  end

  assign o_digit_tick = w_tick;
  assign o_digit_idx  = r_digit_idx;
  assign o_frame_done = w_tick && (r_digit_idx == 3'(DIGITS - 1));

endmodule

// File: rtl/ssd_display_arbiter.sv
// Arbitrates three requesters for one 8-digit seven-segment display.
// The display word and blank mask are only reloaded at frame boundaries so
// the driver never shows a torn frame.
//   ssd_clk, ssd_rst_n : clock, async active-low reset
//   bus (slave)        : requests in; grant, display word/mask, scan timing
//                        and FSM state out
module ssd_display_arbiter
  import ssd_display_arbiter_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                  ssd_clk,
  input  logic                  ssd_rst_n,
  ssd_display_arbiter_if.slave  bus
);

  localparam int                HOLD_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

  arb_state_e        r_state, w_state_nxt;
  logic [1:0]        r_owner, w_owner_nxt;
  logic [1:0]        r_last_owner, w_last_owner_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [31:0]       r_disp_data, w_disp_data_nxt;
  logic [7:0]        r_disp_blank, w_disp_blank_nxt;

  logic              w_frame_done;
  logic              w_digit_tick;
  logic [2:0]        w_digit_idx;
  logic [N_REQ-1:0]  w_owner_oh;
  logic              w_owner_valid;
  logic [N_REQ-1:0]  w_others;
  logic [HOLD_W-1:0] w_hold_inc;
  logic [31:0]       w_owner_data;
  logic [7:0]        w_owner_blank;
  rr_pick_t          w_pick;

  ssd_scan_timer #(.REFRESH_DIV(REFRESH_DIV)) u_scan (
    .ssd_clk      (ssd_clk),
    .ssd_rst_n    (ssd_rst_n),
    .o_digit_tick (w_digit_tick),
    .o_digit_idx  (w_digit_idx),
    .o_frame_done (w_frame_done)
  );

  assign w_owner_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_owner_valid = bus.req_valid[r_owner];
  assign w_others      = bus.req_valid & ~w_owner_oh;
  assign w_owner_data  = bus.req_data[{r_owner, 5'b0} +: 32];
  assign w_owner_blank = bus.req_blank[{r_owner, 3'b0} +: 8];
  assign w_pick        = rr_pick(bus.req_valid, r_last_owner);
  // Frames held so far including the one ending now, saturating.
  assign w_hold_inc    = (r_hold_cnt == HOLD_MAX) ? HOLD_MAX
                                                  : r_hold_cnt + HOLD_W'(1);

  always_ff @(posedge ssd_clk or negedge ssd_rst_n) begin
    if (!ssd_rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd2;
      r_hold_cnt   <= '0;
      r_disp_data  <= '0;
      r_disp_blank <= BLANK_ALL;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_disp_data  <= w_disp_data_nxt;
      r_disp_blank <= w_disp_blank_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_disp_data_nxt  = r_disp_data;
    w_disp_blank_nxt = r_disp_blank;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req_valid) w_state_nxt = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (w_pick.found) begin
          w_state_nxt      = ST_OWN;
          w_owner_nxt      = w_pick.idx;
          w_last_owner_nxt = w_pick.idx;
          w_hold_cnt_nxt   = '0;
        end else begin
          // Nobody left: the display goes dark until the next owner's first frame.
          w_state_nxt      = ST_IDLE;
          w_disp_data_nxt  = '0;
          w_disp_blank_nxt = BLANK_ALL;
        end
      end
      ST_OWN: begin
        if (w_frame_done) begin
          w_disp_data_nxt  = w_owner_data;
          w_disp_blank_nxt = w_owner_blank;
          w_hold_cnt_nxt   = w_hold_inc;
          // An owner that withdrew is released regardless of hold time.
          if (!w_owner_valid || ((w_hold_inc >= HOLD_MAX) && (|w_others)))
            w_state_nxt = ST_SWITCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.grant      = (r_state == ST_OWN) ? w_owner_oh : '0;
  assign bus.disp_data  = r_disp_data;
  assign bus.disp_blank = r_disp_blank;
  assign bus.digit_tick = w_digit_tick;
  assign bus.digit_idx  = w_digit_idx;
  assign bus.frame_done = w_frame_done;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Bench for ssd_display_arbiter with a short refresh period and two-frame hold.
// A reference model predicts every change of {grant, disp_data, disp_blank}
// and the scan timing from elapsed cycles; a monitor compares what the DUT shows.
module tb_ssd_display_arbiter;
  import ssd_display_arbiter_pkg::*;

  localparam int DIV   = 4;
  localparam int HOLD  = 2;
  localparam int FRAME = DIV * 8;
  localparam int TW    = 43;          // {grant, disp_data, disp_blank}
  localparam int W     = 16 + TW;     // {cycle stamp, tuple}

  // ---------------- clock / reset ----------------
  logic ssd_clk   = 1'b0;
  logic ssd_rst_n = 1'b0;
  always #5 ssd_clk = ~ssd_clk;

  ssd_display_arbiter_if bus();

  ssd_display_arbiter #(.REFRESH_DIV(DIV), .HOLD_FRAMES(HOLD)) dut (
    .ssd_clk   (ssd_clk),
    .ssd_rst_n (ssd_rst_n),
    .bus       (bus)
  );

  bit              model_en = 1'b0;
  bit              end_req  = 1'b0;
  bit              end_done = 1'b0;
  logic [W-1:0]    exp_q[$];
  int              checks = 0;
  int              errors = 0;

  // ---------------- reference model ----------------
  // owner < 0 means nobody holds the display; 'switching' marks the single
  // decision cycle between owners.
  int              cyc;
  int              m_owner, m_last, m_frames;
  bit              m_switching;
  logic [31:0]     m_data;
  logic [7:0]      m_blank;
  logic [TW-1:0]   m_t;

  always @(posedge ssd_clk) begin : model
    logic          fd;
    logic [2:0]    v;
    logic [2:0]    g;
    int            pick;
    logic [TW-1:0] t;
    if (!model_en) begin
      cyc = 0; m_owner = -1; m_last = 2; m_frames = 0; m_switching = 1'b0;
      m_data = 32'h0; m_blank = 8'hFF; m_t = {3'b000, 32'h0, 8'hFF};
    end else begin
      fd = ((cyc % FRAME) == FRAME - 1);
      v  = bus.req_valid;
      if (m_switching) begin
        m_switching = 1'b0;
        pick = -1;
        for (int i = 1; i <= 3; i++)
          if (pick < 0 && v[(m_last + i) % 3]) pick = (m_last + i) % 3;
        if (pick < 0) begin
          m_owner = -1; m_data = 32'h0; m_blank = 8'hFF;
        end else begin
          m_owner = pick; m_last = pick; m_frames = 0;
        end
      end else if (m_owner < 0) begin
        if (v != 3'b000) m_switching = 1'b1;
      end else if (fd) begin
        m_data   = bus.req_data[32*m_owner +: 32];
        m_blank  = bus.req_blank[8*m_owner +: 8];
        m_frames = (m_frames < HOLD) ? m_frames + 1 : HOLD;
        if (!v[m_owner]) m_switching = 1'b1;
        else if (m_frames >= HOLD && v != (3'b001 << m_owner)) m_switching = 1'b1;
      end
      cyc++;
      g = (m_owner >= 0 && !m_switching) ? 3'(1 << m_owner) : 3'b000;
      t = {g, m_data, m_blank};
      if (t != m_t) begin
        exp_q.push_back({cyc[15:0], t});
        m_t = t;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [TW-1:0] seen_t = {3'b000, 32'h0, 8'hFF};

  always @(negedge ssd_clk or negedge ssd_rst_n) begin : monitor
    logic [TW-1:0] dut_t;
    logic [W-1:0]  e;
    logic          x_tick, x_fd;
    logic [2:0]    x_idx;
    if (!ssd_rst_n) begin
      #1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain_at_reset pending=%0d required=0", exp_q.size());
        exp_q.delete();
      end
      checks++;
      if (bus.grant !== 3'b000 || bus.disp_data !== 32'h0 || bus.disp_blank !== 8'hFF ||
          bus.digit_tick !== 1'b0 || bus.digit_idx !== 3'd0 || bus.frame_done !== 1'b0 ||
          bus.dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL reset_state got grant=%b data=%h blank=%h tick=%b idx=%0d fd=%b required 000/00000000/ff/0/0/0",
                 bus.grant, bus.disp_data, bus.disp_blank, bus.digit_tick, bus.digit_idx, bus.frame_done);
      end
      seen_t = {3'b000, 32'h0, 8'hFF};
    end else if (model_en) begin
      x_tick = ((cyc % DIV) == DIV - 1);
      x_fd   = ((cyc % FRAME) == FRAME - 1);
      x_idx  = 3'((cyc / DIV) % 8);
      checks++;
      if (bus.digit_tick !== x_tick || bus.digit_idx !== x_idx || bus.frame_done !== x_fd) begin
        errors++;
        $display("FAIL scan cyc=%0d got tick=%b idx=%0d fd=%b required tick=%b idx=%0d fd=%b",
                 cyc, bus.digit_tick, bus.digit_idx, bus.frame_done, x_tick, x_idx, x_fd);
      end
      dut_t = {bus.grant, bus.disp_data, bus.disp_blank};
      if (dut_t !== seen_t) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got grant=%b data=%h blank=%h required no change",
                   cyc, dut_t[42:40], dut_t[39:8], dut_t[7:0]);
        end else begin
          e = exp_q.pop_front();
          if (e !== {cyc[15:0], dut_t}) begin
            errors++;
            $display("FAIL output_change cyc=%0d got grant=%b data=%h blank=%h required cyc=%0d grant=%b data=%h blank=%h",
                     cyc, dut_t[42:40], dut_t[39:8], dut_t[7:0],
                     e[W-1:TW], e[42:40], e[39:8], e[7:0]);
          end
        end
        seen_t = dut_t;
      end
      if (exp_q.size() != 0 && exp_q[0][W-1:TW] <= cyc[15:0]) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missed_change cyc=%0d got grant=%b data=%h blank=%h required grant=%b data=%h blank=%h",
                 cyc, bus.grant, bus.disp_data, bus.disp_blank, e[42:40], e[39:8], e[7:0]);
      end
      if (end_req && !end_done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL final_drain pending=%0d required=0", exp_q.size());
        end
        end_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_wait(input int n);
    repeat (n) @(negedge ssd_clk);
    #2;
  endtask

  task automatic set_slot(input int k, input logic [31:0] d, input logic [7:0] b);
    bus.req_data[32*k +: 32] = d;
    bus.req_blank[8*k +: 8]  = b;
  endtask

  task automatic release_reset();
    ssd_rst_n = 1'b1;
    model_en  = 1'b1;
  endtask

  task automatic apply_reset(input int n);
    bus.req_valid = 3'b000;
    ssd_rst_n     = 1'b0;
    model_en      = 1'b0;
    tick_wait(n);
    release_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_blank = '0;

    // power-on reset held three cycles, then an idle stretch
    tick_wait(3);
    release_reset();
    tick_wait(70);

    // single requester keeps the grant
    set_slot(0, 32'h1234ABCD, 8'h00);
    bus.req_valid = 3'b001;
    tick_wait(100);

    // everyone requesting: rotation with two-frame holds
    apply_reset(3);
    for (int k = 0; k < 3; k++) set_slot(k, $urandom, 8'h00);
    bus.req_valid = 3'b111;
    tick_wait(16 * FRAME + 10);

    // owner 0 withdraws mid-frame while requester 1 waits
    apply_reset(2);
    set_slot(0, 32'hA5A50001, 8'h00);
    set_slot(1, 32'h5A5A0002, 8'h0F);
    bus.req_valid = 3'b001;
    tick_wait(40);
    bus.req_valid = 3'b011;
    tick_wait($urandom_range(2, 18));
    bus.req_valid = 3'b010;
    tick_wait(80);

    // blank mask path, then all requests dropped
    apply_reset(2);
    set_slot(0, 32'h55AA0F0F, 8'hF0);
    bus.req_valid = 3'b001;
    tick_wait(80);
    bus.req_valid = 3'b000;
    tick_wait(60);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        set_slot($urandom_range(0, 2), $urandom, 8'($urandom_range(0, 255)));
      bus.req_valid = 3'($urandom_range(0, 7));
      tick_wait($urandom_range(1, 50));
    end

    // asynchronous reset while owning the display
    apply_reset(2);
    set_slot(0, 32'hCAFE0123, 8'h0F);
    bus.req_valid = 3'b001;
    tick_wait(70);
    bus.req_valid = 3'b000;
    ssd_rst_n     = 1'b0;
    model_en      = 1'b0;
    tick_wait(2);
    release_reset();
    tick_wait(40);

    end_req = 1'b1;
    @(negedge ssd_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
